load_store_unit: RTL



---
 rtl/load_store_unit_pkg.sv | 16 +
 rtl/load_store_unit_lsu_byte_lane.sv | 52 +++++
 rtl/load_store_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared RV32I load/store definitions: funct3 size codes and the LSU state encoding.
package riscv_structures;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_lsu_byte_lane.sv
// Combinational byte/half lane logic: extracts and extends load data, and merges
// sub-word store data into a read word for the read-modify-write path.
module lsu_byte_lane
    import riscv_structures::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_lane)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_load_data = i_rdata;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h000000, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0000, w_half};
            default: o_load_data = i_rdata;
        endcase

        // Store size comes from funct3[1:0]; only byte and half reach the merge.
        o_merged = i_rdata;
        if (i_funct3[1:0] == 2'b00) begin
            case (i_lane)
                2'd0: o_merged[7:0]   = i_wdata[7:0];
                2'd1: o_merged[15:8]  = i_wdata[7:0];
                2'd2: o_merged[23:16] = i_wdata[7:0];
                default: o_merged[31:24] = i_wdata[7:0];
            endcase
        end else if (i_lane[1]) begin
            o_merged[31:16] = i_wdata[15:0];
        end else begin
            o_merged[15:0] = i_wdata[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-only memory (combinational read, synchronous write).
// Define LSU_BOUNDS_CHECK_EN to reject accesses whose word index is >= MEM_WORDS.
module load_store_unit
    import riscv_structures::*;
#(
    parameter int MEM_WORDS = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    lsu_state_e  r_state;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_misaligned;
    logic        w_invalid;
    logic        w_oob;
    logic        w_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_misaligned = ((r_f3[1:0] == 2'b01) && r_addr[0]) ||
                          ((r_f3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_invalid    = r_we ? (r_f3 > F3_W) : ((r_f3 == 3'b011) || (r_f3[2:1] == 2'b11));
    assign w_oob        = BOUNDS_EN && ({2'b00, r_addr[31:2]} >= 32'(MEM_WORDS));
    assign w_err        = w_misaligned || w_invalid || w_oob;

    lsu_byte_lane u_lane (
        .i_funct3    (r_f3),
        .i_lane      (r_addr[1:0]),
        .i_rdata     (mem_read_data),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    // Write strobe is decoded from state so an asynchronous reset kills it immediately.
    assign req_ready        = (r_state == IDLE);
    assign mem_address      = {r_addr[31:2], 2'b00};
    assign mem_write_enable = (r_state == WRITE) ||
                              ((r_state == ACCESS) && r_we && !w_err && (r_f3 == F3_W));
    assign mem_write_data   = (r_state == WRITE) ? r_merged : r_wdata;
    assign resp_valid       = r_resp_valid;
    assign resp_err         = r_resp_err;
    assign resp_rdata       = r_resp_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_f3         <= 3'b000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_merged     <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_f3    <= req_funct3;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_err) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_state      <= IDLE;
                    end else if (!r_we) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load_data;
                        r_state      <= IDLE;
                    end else if (r_f3 == F3_W) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_merged <= w_merged;
                        r_state  <= WRITE;
                    end
                end
                WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
